// File: rtl/msk_and_hpc2_sequencer_pkg.sv
// Shared sizing helpers for the HPC2 AND issue sequencer and its share FIFO.
package msk_and_hpc2_sequencer_pkg;

  localparam int D_DEFAULT          = 2;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  function automatic int hpc2rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/MSKand_hpc2o2.sv
// Second-order-pipelined HPC2 masked AND: inb/rnd one cycle before ina, output registered.
module MSKand_hpc2o2 #(
  parameter int d       = 2,
  parameter int hpc2rnd = msk_and_hpc2_sequencer_pkg::hpc2rnd(d)
) (
  input  logic               clk,
  input  logic [d-1:0]       ina,
  input  logic [d-1:0]       inb,
  input  logic [d-1:0]       inb_prev,
  input  logic [hpc2rnd-1:0] rnd,
  output logic [d-1:0]       out_c
);

  logic [d-1:0][d-1:0] rmat_d, rmat_q;
  logic [d-1:0][d-1:0] blind_d, blind_q;
  logic [d-1:0]        out_d, out_q;

  // Fresh bit r_ij is shared by share pair (i,j); b_j is blinded with it before a_i arrives.
  always_comb begin
    rmat_d  = '0;
    blind_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        rmat_d[i][j] = rnd[i*d - i*(i+1)/2 + (j-i-1)];
        rmat_d[j][i] = rnd[i*d - i*(i+1)/2 + (j-i-1)];
      end
    end
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != j) blind_d[i][j] = inb[j] ^ rmat_d[i][j];
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < d; i++) begin
      out_d[i] = ina[i] & inb_prev[i];
      for (int j = 0; j < d; j++) begin
        if (i != j) out_d[i] = out_d[i] ^ (~ina[i] & rmat_q[i][j]) ^ (ina[i] & blind_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    rmat_q  <= rmat_d;
    blind_q <= blind_d;
    out_q   <= out_d;
  end

  assign out_c = out_q;

endmodule

// File: rtl/msk_share_fifo.sv
// Resettable circular FIFO of d-share words; storage and head output are zero-cleared.
module msk_share_fifo
  import msk_and_hpc2_sequencer_pkg::*;
#(
  parameter int d          = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [d-1:0]                        wr_data,
  input  logic                                rd_en,
  output logic [d-1:0]                        rd_data,
  output logic                                rd_valid,
  output logic [credit_width(FIFO_DEPTH)-1:0] count
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int CW = credit_width(FIFO_DEPTH);

  logic [d-1:0]  mem_d [FIFO_DEPTH];
  logic [d-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          rd_fire;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_fire  = rd_en & (count_q != '0);
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_fire);
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (rd_fire) rd_ptr_d = ptr_next(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/msk_and_hpc2_sequencer.sv
// Issue controller for MSKand_hpc2o2: operand/randomness handshakes, staggered drive,
// two-stage valid pipe and a credit-protected output FIFO absorbing backpressure.
module msk_and_hpc2_sequencer #(
  parameter int d          = msk_and_hpc2_sequencer_pkg::D_DEFAULT,
  parameter int hpc2rnd    = msk_and_hpc2_sequencer_pkg::hpc2rnd(d),
  parameter int FIFO_DEPTH = msk_and_hpc2_sequencer_pkg::FIFO_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [d-1:0]       in_a,
  input  logic [d-1:0]       in_b,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [hpc2rnd-1:0] rnd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [d-1:0]       out_data,
  output logic               busy
);

  import msk_and_hpc2_sequencer_pkg::*;

  localparam int CW = credit_width(FIFO_DEPTH);

  logic [CW-1:0]      credit_d, credit_q;
  logic               v1_d, v1_q, v2_d, v2_q;
  logic [d-1:0]       a_d, a_q, b_d, b_q;
  logic               credit_ok, issue, pop;
  logic [d-1:0]       gadget_ina, gadget_inb, gadget_inb_prev, gadget_out;
  logic [hpc2rnd-1:0] gadget_rnd;
  logic [CW-1:0]      fifo_count;

  assign credit_ok = (credit_q != '0);
  assign in_ready  = rnd_valid & credit_ok;
  assign rnd_ready = in_valid & credit_ok;
  assign issue     = in_valid & rnd_valid & credit_ok;
  assign pop       = out_valid & out_ready;

  // Non-issue cycles feed all-zero sharings so unrelated operands never meet in the gadget.
  assign gadget_inb      = issue ? in_b : '0;
  assign gadget_rnd      = issue ? rnd_data : '0;
  assign gadget_ina      = a_q;
  assign gadget_inb_prev = b_q;

  always_comb begin
    a_d      = issue ? in_a : '0;
    b_d      = issue ? in_b : '0;
    v1_d     = issue;
    v2_d     = v1_q;
    credit_d = credit_q;
    if (issue && !pop)      credit_d = credit_q - 1'b1;
    else if (pop && !issue) credit_d = credit_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= CW'(FIFO_DEPTH);
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      credit_q <= credit_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  MSKand_hpc2o2 #(
    .d       (d),
    .hpc2rnd (hpc2rnd)
  ) u_gadget (
    .clk      (clk),
    .ina      (gadget_ina),
    .inb      (gadget_inb),
    .inb_prev (gadget_inb_prev),
    .rnd      (gadget_rnd),
    .out_c    (gadget_out)
  );

  // Credits reserve a slot at issue time, so the v2 write can never hit a full FIFO.
  msk_share_fifo #(
    .d          (d),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (v2_q),
    .wr_data  (gadget_out),
    .rd_en    (pop),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

  assign busy = v1_q | v2_q | (fifo_count != '0);

  credit_underflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && !pop && credit_q == '0));
  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !issue && credit_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_msk_and_hpc2_sequencer.sv
// Directed + randomized bench for msk_and_hpc2_sequencer against a queue-based model
// of issue credits, 2-edge latency and in-order FIFO delivery.
module tb_msk_and_hpc2_sequencer;

  localparam int D     = 2;
  localparam int DEPTH = 4;
  localparam int RW    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, rnd_valid, out_ready;
  logic [D-1:0]  in_a, in_b;
  logic [RW-1:0] rnd_data;
  logic          in_ready, rnd_ready, out_valid, busy;
  logic [D-1:0]  out_data;

  always #5 clk = ~clk;

  msk_and_hpc2_sequencer #(
    .d          (D),
    .hpc2rnd    (RW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    int unsigned due;
    bit          val;
  } flight_t;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          credit;
  int unsigned edge_n;
  bit          fifo_q[$];
  flight_t     flight_q[$];
  bit          prev_issue, cur_issue, cur_pop, cur_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] share(input bit x);
    logic [D-1:0] s;
    s      = D'($urandom);
    s[D-1] = ^s[D-2:0] ^ x;
    return s;
  endfunction

  task automatic applyStimulus(input bit iv, input bit rv, input bit ordy,
                               input logic [D-1:0] ia, input logic [D-1:0] ib,
                               input logic [RW-1:0] r);
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = ordy;
    in_a      = ia;
    in_b      = ib;
    rnd_data  = r;
  endtask

  task automatic applyRandom(input bit iv, input bit rv, input bit ordy);
    applyStimulus(iv, rv, ordy, share(1'($urandom)), share(1'($urandom)), RW'($urandom));
  endtask

  task automatic checkOutput();
    bit exp_ov;
    cur_issue = in_valid && rnd_valid && (credit > 0);
    exp_ov    = (fifo_q.size() > 0);
    cur_pop   = exp_ov && out_ready;
    cur_val   = (^in_a) & (^in_b);
    chk("in_ready",  32'(in_ready),  32'(rnd_valid && credit > 0));
    chk("rnd_ready", 32'(rnd_ready), 32'(in_valid && credit > 0));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("busy",      32'(busy),      32'(exp_ov || flight_q.size() > 0));
    chk("credit",    32'(dut.credit_q), 32'(credit));
    if (exp_ov) chk("out_check", 32'(^out_data), 32'(fifo_q[0]));
    else        chk("out_data_empty", 32'(out_data), 32'd0);
    if (cur_issue) begin
      chk("gadget_inb_issue", 32'(dut.gadget_inb), 32'(in_b));
    end else begin
      chk("gadget_inb_idle", 32'(dut.gadget_inb), 32'd0);
      chk("gadget_rnd_idle", 32'(dut.gadget_rnd), 32'd0);
    end
    if (!prev_issue) begin
      chk("gadget_ina_idle",      32'(dut.gadget_ina), 32'd0);
      chk("gadget_inb_prev_idle", 32'(dut.gadget_inb_prev), 32'd0);
    end
  endtask

  task automatic cycle();
    #1;
    checkOutput();
    @(posedge clk);
    edge_n++;
    if (cur_pop) void'(fifo_q.pop_front());
    while (flight_q.size() > 0 && flight_q[0].due == edge_n) begin
      fifo_q.push_back(flight_q[0].val);
      void'(flight_q.pop_front());
    end
    if (cur_issue) flight_q.push_back('{due: edge_n + 2, val: cur_val});
    credit     = credit + (cur_pop ? 1 : 0) - (cur_issue ? 1 : 0);
    prev_issue = cur_issue;
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    credit     = DEPTH;
    prev_issue = 1'b0;
    fifo_q.delete();
    flight_q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_credit",    32'(dut.credit_q), 32'(DEPTH));
    chk("rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    edge_n = 0;
    rst    = 1'b1;
    doReset();

    $display("[TB] single ops");
    for (int i = 0; i < 3; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 2'b11, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("[TB] back-to-back");
    for (int i = 0; i < 8; i++) begin applyRandom(1'b1, 1'b1, 1'b1); cycle(); end
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("[TB] backpressure");
    for (int i = 0; i < 7; i++) begin applyRandom(1'b1, 1'b1, 1'b0); cycle(); end
    applyRandom(1'b1, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b1, 1'b1, 1'b0); cycle(); end
    for (int i = 0; i < 8; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("[TB] randomness stall");
    for (int i = 0; i < 3; i++) begin applyRandom(1'b1, 1'b0, 1'b1); cycle(); end
    applyRandom(1'b1, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("[TB] reset in flight");
    applyRandom(1'b1, 1'b1, 1'b1); cycle();
    doReset();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end
    applyRandom(1'b1, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("[TB] random mix");
    for (int i = 0; i < 40; i++) begin
      applyRandom(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      cycle();
    end
    for (int i = 0; i < 10; i++) begin applyRandom(1'b0, 1'b0, 1'b1); cycle(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
